// File: rtl/cube_frame_tx.sv
// cube0414 frame transmitter: streams one 8x64 RGB frame from frame RAM as command/data bytes.
// Optional address-map phase is built when CUBE0414_ADDR_MAP_EN is defined.
module cube_frame_tx #(
`ifdef CUBE0414_ADDR_MAP_EN
  parameter logic [7:0] CUBE0414_ADDR_WR = 8'hcc,
`endif
  parameter logic [7:0] CUBE0414_DATA_WR = 8'hda
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        rd_en_out,
  output logic [8:0]  rd_addr_out,
  input  logic [23:0] rd_data_in,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic [7:0]  byte_data_out,
  output logic        dc_out
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef CUBE0414_ADDR_MAP_EN
    ADDR_CMD,
    ADDR_DATA,
`endif
    DATA_CMD,
    RD_REQ,
    RD_WAIT,
    COLOR,
    DONE
  } state_e;

  state_e      state_q;
  logic [5:0]  led_q;
  logic [2:0]  layer_q;
  logic [1:0]  color_q;
  logic [15:0] rgb_q;
  logic        busy_q;
  logic        done_q;
  logic        rd_en_q;
  logic [8:0]  rd_addr_q;
  logic        valid_q;
  logic [7:0]  data_q;
  logic        dc_q;
  logic        xfer;

  assign xfer = valid_q & byte_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      led_q     <= '0;
      layer_q   <= '0;
      color_q   <= '0;
      rgb_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      dc_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            dc_q    <= 1'b0;
`ifdef CUBE0414_ADDR_MAP_EN
            data_q  <= CUBE0414_ADDR_WR;
            state_q <= ADDR_CMD;
`else
            data_q  <= CUBE0414_DATA_WR;
            state_q <= DATA_CMD;
`endif
          end
        end
`ifdef CUBE0414_ADDR_MAP_EN
        ADDR_CMD: begin
          if (xfer) begin
            led_q   <= '0;
            data_q  <= '0;
            dc_q    <= 1'b1;
            state_q <= ADDR_DATA;
          end
        end
        ADDR_DATA: begin
          if (xfer) begin
            if (led_q == 6'd63) begin
              led_q   <= '0;
              data_q  <= CUBE0414_DATA_WR;
              dc_q    <= 1'b0;
              state_q <= DATA_CMD;
            end else begin
              led_q  <= led_q + 6'd1;
              data_q <= {2'b00, led_q + 6'd1};
            end
          end
        end
`endif
        DATA_CMD: begin
          if (xfer) begin
            valid_q   <= 1'b0;
            layer_q   <= 3'd7;
            led_q     <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= {3'd7, 6'd0};
            state_q   <= RD_REQ;
          end
        end
        // rd_en/rd_addr are issued on the edge entering RD_REQ so the strobe is visible during it
        RD_REQ: state_q <= RD_WAIT;
        RD_WAIT: begin
          rgb_q   <= rd_data_in[15:0];
          data_q  <= rd_data_in[23:16];
          dc_q    <= 1'b1;
          valid_q <= 1'b1;
          color_q <= '0;
          state_q <= COLOR;
        end
        COLOR: begin
          if (xfer) begin
            case (color_q)
              2'd0: begin
                data_q  <= rgb_q[15:8];
                color_q <= 2'd1;
              end
              2'd1: begin
                data_q  <= rgb_q[7:0];
                color_q <= 2'd2;
              end
              default: begin
                valid_q <= 1'b0;
                color_q <= '0;
                if (led_q != 6'd63) begin
                  led_q     <= led_q + 6'd1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {layer_q, led_q + 6'd1};
                  state_q   <= RD_REQ;
                end else if (layer_q != 3'd0) begin
                  led_q     <= '0;
                  layer_q   <= layer_q - 3'd1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {layer_q - 3'd1, 6'd0};
                  state_q   <= RD_REQ;
                end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end
              end
            endcase
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign rd_en_out      = rd_en_q;
  assign rd_addr_out    = rd_addr_q;
  assign byte_valid_out = valid_q;
  assign byte_data_out  = data_q;
  assign dc_out         = dc_q;

endmodule

// File: tb/tb_cube_frame_tx.sv
// Directed self-checking bench for cube_frame_tx; expected byte stream is built from the RAM model.
// Expectations follow CUBE0414_ADDR_MAP_EN the same way the design does.
module tb_cube_frame_tx;

`ifdef CUBE0414_ADDR_MAP_EN
  localparam int EXP_LEN = 1602;
  localparam int EXP_CYC = 2627;
  localparam logic [7:0] FIRST_CMD = 8'hcc;
  localparam int DA_IDX = 65;
`else
  localparam int EXP_LEN = 1537;
  localparam int EXP_CYC = 2562;
  localparam logic [7:0] FIRST_CMD = 8'hda;
  localparam int DA_IDX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [23:0] rd_data = '0;
  logic        busy, done, rd_en, valid, dc;
  logic [8:0]  rd_addr;
  logic [7:0]  data;

  always #5 clk = ~clk;

  cube_frame_tx dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .start_in       (start),
    .busy_out       (busy),
    .done_out       (done),
    .rd_en_out      (rd_en),
    .rd_addr_out    (rd_addr),
    .rd_data_in     (rd_data),
    .byte_valid_out (valid),
    .byte_ready_in  (ready),
    .byte_data_out  (data),
    .dc_out         (dc)
  );

  logic [23:0] mem [512];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  bit bp = 1'b0;
  always @(posedge clk) begin
    #1;
    ready = bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit          collect = 1'b0;
  logic [8:0]  cap [$];
  logic [8:0]  exp_q [$];
  int          done_cnt = 0;
  int          stall_viol = 0;
  logic        pv = 1'b0, pr = 1'b0, pdc = 1'b0;
  logic [7:0]  pd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!valid || data !== pd || dc !== pdc)) stall_viol++;
      if (collect && valid && ready) cap.push_back({dc, data});
      if (collect && done) done_cnt++;
      pv = valid; pr = ready; pd = data; pdc = dc;
    end
  end

  function automatic void build_exp();
    logic [23:0] w;
    exp_q.delete();
`ifdef CUBE0414_ADDR_MAP_EN
    exp_q.push_back({1'b0, 8'hcc});
    for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, 8'(i)});
`endif
    exp_q.push_back({1'b0, 8'hda});
    for (int l = 7; l >= 0; l--)
      for (int e = 0; e < 64; e++) begin
        w = mem[l * 64 + e];
        exp_q.push_back({1'b1, w[23:16]});
        exp_q.push_back({1'b1, w[15:8]});
        exp_q.push_back({1'b1, w[7:0]});
      end
  endfunction

  task automatic compare_stream(input string tag);
    int nm;
    int first_bad;
    nm = 0;
    first_bad = -1;
    check({tag, "_len"}, cap.size(), EXP_LEN);
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) begin
        nm++;
        if (first_bad < 0) first_bad = i;
      end
    if (first_bad >= 0)
      $display("  %s first differing byte %0d: got %h want %h", tag, first_bad,
               cap[first_bad], exp_q[first_bad]);
    check({tag, "_mismatched_bytes"}, nm, 0);
  endtask

  task automatic run_frame(input bit extra_start, output int cycles);
    bit got;
    cap.delete();
    done_cnt = 0;
    collect = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        check("busy_after_start", busy, 1);
        check("first_byte", {valid, dc, data}, {1'b1, 1'b0, FIRST_CMD});
      end
      start = (extra_start && (cycles == 100 || cycles == 1500)) ? 1'b1 : 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("busy_at_done", busy, 0);
    repeat (4) @(negedge clk);
    collect = 1'b0;
    check("done_pulses", done_cnt, 1);
  endtask

  logic [21:0] all_outs;
  assign all_outs = {busy, done, rd_en, rd_addr, valid, data, dc};

  int cyc;

  initial begin
    for (int a = 0; a < 512; a++) begin
      logic [8:0] av;
      av = 9'(a);
      mem[a] = {5'd0, av[8:6], 2'd0, av[5:0], av[7:0] ^ 8'h5a};
    end
    mem[9'h1c5] = 24'h123456;
    build_exp();

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", all_outs, 0);

    run_frame(1'b0, cyc);
    compare_stream("frame_nobp");
    check("frame_cycles", cyc, EXP_CYC);
    check("byte0", cap.size() > 0 ? cap[0] : 9'h1ff, {1'b0, FIRST_CMD});
    check("da_cmd", cap.size() > DA_IDX ? cap[DA_IDX] : 9'h1ff, {1'b0, 8'hda});
`ifdef CUBE0414_ADDR_MAP_EN
    check("addr_byte1", cap.size() > 1 ? cap[1] : 9'h1ff, {1'b1, 8'h00});
    check("addr_byte64", cap.size() > 64 ? cap[64] : 9'h1ff, {1'b1, 8'h3f});
`endif
    check("l7_led5_r", cap.size() > DA_IDX + 16 ? cap[DA_IDX + 16] : 9'h1ff, {1'b1, 8'h12});
    check("l7_led5_g", cap.size() > DA_IDX + 17 ? cap[DA_IDX + 17] : 9'h1ff, {1'b1, 8'h34});
    check("l7_led5_b", cap.size() > DA_IDX + 18 ? cap[DA_IDX + 18] : 9'h1ff, {1'b1, 8'h56});
    check("last_byte", cap.size() > 0 ? cap[cap.size() - 1] : 9'h1ff, {1'b1, 8'h3f ^ 8'h5a});

    bp = 1'b1;
    stall_viol = 0;
    run_frame(1'b0, cyc);
    compare_stream("frame_bp");
    check("stall_stability", stall_viol, 0);

    run_frame(1'b1, cyc);
    compare_stream("frame_restart_ignored");
    check("stall_stability2", stall_viol, 0);
    bp = 1'b0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (400) @(negedge clk);
    check("busy_mid_frame", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", all_outs, 0);

    run_frame(1'b0, cyc);
    compare_stream("frame_after_reset");
    check("frame_cycles_after_reset", cyc, EXP_CYC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
